result_drain: RTL and testbench

RESULT_DRAIN -- requirements
Module: result_drain

---
 rtl/result_drain_pkg.sv | 14 +
 rtl/result_drain_fifo.sv | 69 ++++++
 rtl/result_drain.sv | 163 ++++++++++++++++
 tb/tb_result_drain.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/result_drain_pkg.sv
// Shared definitions for the result drain: default word/row sizes and FSM states.
package result_drain_pkg;

  localparam int WORD_SIZE = 32;
  localparam int ROW_SIZE  = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/result_drain_fifo.sv
// drain_fifo: 2-entry FIFO between the buffer read port and the result stream.
// The head word reads as zero while empty so the stream output is clean at rest.
module drain_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] data,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;
  logic         do_push_s;
  logic         do_pop_s;

  // Qualify requests: pop only when data exists, push into a full FIFO only alongside a pop.
  always_comb begin
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    if (pop && (count_r != 2'd0)) begin
      do_pop_s = 1'b1;
    end else begin
      do_pop_s = 1'b0;
    end
    if (push && ((count_r != 2'd2) || do_pop_s)) begin
      do_push_s = 1'b1;
    end else begin
      do_push_s = 1'b0;
    end
  end

  // Storage, pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_r[0] <= {W{1'b0}};
      mem_r[1] <= {W{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign count = count_r;
  assign full  = (count_r == 2'd2);
  assign empty = (count_r == 2'd0);
  assign data  = (count_r == 2'd0) ? {W{1'b0}} : mem_r[rd_ptr_r];

endmodule

// File: rtl/result_drain.sv
// result_drain: reads rows 0..len-1 from the output global buffer and streams
// them through a 2-entry FIFO with valid/ready handshaking.
// Optional feature: define RESULT_DRAIN_CHECKSUM_EN to add a running checksum
// port summing every transferred word.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int WORD_W = WORD_SIZE,
  parameter int IDX_W  = ROW_SIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W:0]    len,
  output logic              gb_rd_en,
  output logic [IDX_W-1:0]  gb_idx,
  input  logic [WORD_W-1:0] gb_dout,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done
`ifdef RESULT_DRAIN_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0] checksum
`endif
);

  localparam int             MAX_LEN_I = 1 << IDX_W;
  localparam logic [IDX_W:0] MAX_LEN   = MAX_LEN_I[IDX_W:0];
  localparam logic [IDX_W:0] ONE       = {{IDX_W{1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_s;
  logic [IDX_W:0]    len_r;
  logic [IDX_W:0]    idx_r;     // one extra bit so the terminal count never aliases row 0
  logic [IDX_W:0]    len_clamp_s;
  logic              primed_r;  // delays the first read one cycle after entering STREAM
  logic              vld_r;     // a read was issued last cycle; its data is on gb_dout now
  logic              rd_s;
  logic              pop_s;
  logic [2:0]        occ_s;
  logic [1:0]        fifo_count_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;

  // Clamp the requested length and compute projected FIFO occupancy for read credit.
  always_comb begin
    len_clamp_s = (len > MAX_LEN) ? MAX_LEN : len;
    pop_s       = dout_valid & dout_ready;
    occ_s       = {1'b0, fifo_count_s} + {2'b00, vld_r} - {2'b00, pop_s};
  end

  // Next-state and read-issue decode.
  always_comb begin
    state_s = state_r;
    rd_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (len_clamp_s != {(IDX_W+1){1'b0}}) begin
            state_s = ST_STREAM;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (primed_r && (occ_s < 3'd2) && !(fifo_full_s && !pop_s)) begin
          rd_s = 1'b1;
        end else begin
          rd_s = 1'b0;
        end
        if (rd_s && (idx_r == (len_r - ONE))) begin
          state_s = ST_FLUSH;
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_FLUSH: begin
        if (!vld_r && fifo_empty_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Length latch, row counter and in-flight tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_r    <= {(IDX_W+1){1'b0}};
      idx_r    <= {(IDX_W+1){1'b0}};
      primed_r <= 1'b0;
      vld_r    <= 1'b0;
    end else begin
      vld_r    <= rd_s;
      primed_r <= (state_r == ST_STREAM);
      if (state_r == ST_IDLE) begin
        idx_r <= {(IDX_W+1){1'b0}};
        if (start) begin
          len_r <= len_clamp_s;
        end
      end else if (rd_s) begin
        idx_r <= idx_r + ONE;
      end
    end
  end

  drain_fifo #(.W(WORD_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vld_r),
    .pop   (pop_s),
    .din   (gb_dout),
    .data  (dout),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign gb_rd_en   = rd_s;
  assign gb_idx     = rd_s ? idx_r[IDX_W-1:0] : {IDX_W{1'b0}};
  assign dout_valid = !fifo_empty_s;
  assign busy       = (state_r == ST_STREAM) || (state_r == ST_FLUSH);
  assign done       = (state_r == ST_DONE);

`ifdef RESULT_DRAIN_CHECKSUM_EN
  logic [WORD_W-1:0] checksum_r;

  // Running sum of transferred words; cleared when a drain is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum_r <= {WORD_W{1'b0}};
    end else if ((state_r == ST_IDLE) && start) begin
      checksum_r <= {WORD_W{1'b0}};
    end else if (pop_s) begin
      checksum_r <= checksum_r + dout;
    end
  end

  assign checksum = checksum_r;
`endif

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: a behavioural buffer returns 0x1000+row,
// and each drain is scored against the expected word sequence and timing.
module tb_result_drain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  len;
  logic        gb_rd_en;
  logic [4:0]  gb_idx;
  logic [31:0] gb_dout;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        busy;
  logic        done;
`ifdef RESULT_DRAIN_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  result_drain dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .gb_rd_en   (gb_rd_en),
    .gb_idx     (gb_idx),
    .gb_dout    (gb_dout),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done)
`ifdef RESULT_DRAIN_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  // Buffer model: row r holds 0x1000+r, returned the cycle after the read; noise otherwise.
  always @(posedge clk) begin
    if (gb_rd_en) gb_dout <= 32'h0000_1000 + 32'(gb_idx);
    else          gb_dout <= $urandom;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One drain request. mode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready.
  // inject_at: cycle to pulse a spurious start (len=3); rst_at: cycle to pulse reset.
  task automatic run_drain(input int l, input int mode, input int inject_at, input int rst_at);
    int          exp_len;
    int          issued;
    int          xfer;
    int          done_cnt;
    int          first_v;
    int          done_n;
    logic [31:0] sum;
    logic        stalled;
    logic [31:0] held;
    exp_len  = (l > 32) ? 32 : l;
    issued   = 0;
    xfer     = 0;
    done_cnt = 0;
    first_v  = -1;
    done_n   = -1;
    sum      = 32'd0;
    stalled  = 1'b0;
    held     = 32'd0;
    @(negedge clk);
    start      = 1'b1;
    len        = 6'(l);
    dout_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
      if (n == inject_at) begin start = 1'b1; len = 6'd3; end
      if (n == inject_at + 1) start = 1'b0;
      if (n == rst_at) rst_n = 1'b0;
      if (n == rst_at + 1) rst_n = 1'b1;
      case (mode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = ((n % 4) == 0) || ((n % 4) == 3);
        default: dout_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (rst_at >= 0 && n >= rst_at) begin
        if (n == rst_at + 1) begin
          check_eq("rst_gb_rd_en", gb_rd_en, 0);
          check_eq("rst_gb_idx", gb_idx, 0);
          check_eq("rst_dout", dout, 0);
          check_eq("rst_dout_valid", dout_valid, 0);
          check_eq("rst_busy", busy, 0);
          check_eq("rst_done", done, 0);
        end else if (n > rst_at + 1) begin
          check_eq("post_rst_quiet", {29'd0, done, dout_valid, gb_rd_en}, 0);
        end
        if (n == rst_at + 6) break;
      end else begin
        if (done_n >= 0) begin
          check_eq("done_pulse_width", done, 0);
          check_eq("busy_after_done", busy, 0);
          break;
        end
        if (n == 1 && exp_len > 0) check_eq("busy_streaming", busy, 1);
        if (gb_rd_en) begin
          check_eq("rd_idx_order", gb_idx, 32'(issued));
          check_eq("rd_credit", ((issued - xfer - ((dout_valid && dout_ready) ? 1 : 0)) < 2), 1);
          issued++;
        end
        if (stalled) begin
          check_eq("stall_valid", dout_valid, 1);
          check_eq("stall_data", dout, held);
        end
        if (dout_valid) begin
          if (first_v < 0) first_v = n;
          if (dout_ready) begin
            check_eq("word", dout, 32'h0000_1000 + 32'(xfer));
            if (mode == 0) check_eq("no_bubble", 32'(n), 32'(3 + xfer));
            sum     = sum + dout;
            xfer++;
            stalled = 1'b0;
          end else begin
            stalled = 1'b1;
            held    = dout;
          end
        end
        if (done) begin
          done_cnt++;
          done_n = n;
          check_eq("xfer_at_done", 32'(xfer), 32'(exp_len));
          check_eq("busy_at_done", busy, 0);
`ifdef RESULT_DRAIN_CHECKSUM_EN
          check_eq("checksum", checksum, sum);
`endif
        end
      end
    end
    if (rst_at < 0) begin
      if (done_n < 0) check_eq("timeout_no_done", 0, 1);
      check_eq("done_count", 32'(done_cnt), 1);
      check_eq("reads_issued", 32'(issued), 32'(exp_len));
      check_eq("words_xfer", 32'(xfer), 32'(exp_len));
      if (exp_len == 0) begin
        check_eq("len0_done_cycle", 32'(done_n), 0);
        check_eq("len0_no_valid", 32'(first_v), 32'hFFFF_FFFF);
      end else if (mode == 0) begin
        check_eq("first_valid_latency", 32'(first_v), 3);
        check_eq("done_cycle", 32'(done_n), 32'(exp_len + 4));
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    len        = 6'd0;
    dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_gb_rd_en", gb_rd_en, 0);
    check_eq("reset_gb_idx", gb_idx, 0);
    check_eq("reset_dout", dout, 0);
    check_eq("reset_dout_valid", dout_valid, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    rst_n = 1'b1;

    run_drain(32, 0, -1, -1);   // full drain, no backpressure
    run_drain(5, 1, -1, -1);    // patterned backpressure
    run_drain(0, 0, -1, -1);    // empty request
    run_drain(40, 0, -1, -1);   // clamp to 32
    run_drain(32, 0, 10, -1);   // spurious start mid-drain
    run_drain(32, 0, -1, 12);   // reset while words 10..11 are in flight
    run_drain(2, 0, -1, -1);    // clean restart after abort
    run_drain(4, 0, -1, -1);    // checksum 0x4006 when enabled
    for (int k = 0; k < 6; k++) begin
      run_drain(int'($urandom_range(0, 40)), 2, -1, -1);
    end
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
